// File: rtl/cpr_rc_pkg.sv
// Shared types and constants for the CPR RC ring frequency meter.
// Optional threshold compare is enabled with CPR_FREQ_THRESH_EN.
package cpr_rc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAKE,
    MEAS,
    DONE
  } cpr_meas_state_e;

  localparam int SETTLE_CYCLES   = 8;
  localparam int SETTLE_W        = $clog2(SETTLE_CYCLES);

  localparam int WIN_W_DEF       = 16;
  localparam int CNT_W_DEF       = 12;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cpr_sync.sv
// Resettable multi-flop synchronizer for the asynchronous ring output.
// Reset value is 0 on every stage.
module cpr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_q[STAGES-1];

endmodule

// File: rtl/cpr_rc_freq_meter.sv
// Counts RC ring rising edges over a programmable clk_i window.
// Optional slow-ring compare: define CPR_FREQ_THRESH_EN.
module cpr_rc_freq_meter
  import cpr_rc_pkg::*;
#(
  parameter int WIN_W       = WIN_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             rc_clk_i,
  output logic             pd_rc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
`ifdef CPR_FREQ_THRESH_EN
  ,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             slow_o
`endif
);

  cpr_meas_state_e r_state;
  cpr_meas_state_e w_state_nxt;

  logic [WIN_W-1:0]    r_left;
  logic [SETTLE_W-1:0] r_settle;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_prev;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf_q;

  logic             w_sync;
  logic             w_inc;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  cpr_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rc_clk_i),
    .q_o    (w_sync)
  );

  assign w_inc = (r_state == MEAS) &&
                 w_sync && !r_prev;
  assign w_sat = &r_cnt;

  assign w_cnt_nxt = (w_inc && !w_sat) ?
                     r_cnt + CNT_W'(1) : r_cnt;
  assign w_ovf_nxt = r_ovf | (w_inc & w_sat);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = WAKE;
      end
      WAKE: begin
        if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          if (r_left == '0) w_state_nxt = DONE;
          else              w_state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (r_left == WIN_W'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_left   <= '0;
      r_settle <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_prev   <= 1'b0;
      r_count  <= '0;
      r_ovf_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_sync;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_left   <= win_len_i;
            r_settle <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
          end
        end
        WAKE: begin
          r_settle <= r_settle + SETTLE_W'(1);
        end
        MEAS: begin
          r_left <= r_left - WIN_W'(1);
          r_cnt  <= w_cnt_nxt;
          r_ovf  <= w_ovf_nxt;
        end
        default: ;
      endcase
      // Result includes an edge seen in the final MEAS cycle
      if (w_state_nxt == DONE) begin
        r_count <= w_cnt_nxt;
        r_ovf_q <= w_ovf_nxt;
      end
    end
  end

`ifdef CPR_FREQ_THRESH_EN
  logic r_slow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slow <= 1'b0;
    end else if (r_state == DONE) begin
      r_slow <= (r_cnt < thresh_i);
    end
  end

  assign slow_o = r_slow;
`endif

  // Ring runs only while waking or measuring; reset forces IDLE
  assign pd_rc_o = !((r_state == WAKE) ||
                     (r_state == MEAS));
  assign busy_o  = (r_state != IDLE);
  assign done_o  = (r_state == DONE);
  assign count_o = r_count;
  assign ovf_o   = r_ovf_q;

endmodule
